// File: rtl/morra_driver.sv
`default_nettype none
// morra_driver: runs one morra match against an external referee.
// It forwards move pairs, samples the referee's results and keeps saturating round tallies.
module morra_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] n_extra,
  input  logic       move_valid,
  input  logic [1:0] move_p1,
  input  logic [1:0] move_p2,
  output logic       move_ready,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  output logic       INIZIA,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [4:0] wins_p1,
  output logic [4:0] wins_p2,
  output logic [4:0] rejected
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_COLLECT = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t     state_q;
  logic [1:0] primo_q, secondo_q, result_q, mv1_q, mv2_q;
  logic       inizia_q, ready_q, busy_q, done_q;
  logic [4:0] w1_q, w2_q, rej_q;
  logic [4:0] w1_d, w2_d, rej_d;
  logic [6:0] total_d;

  // Tallies as they would stand after the round being collected; each one stops at 31.
  always_comb begin
    w1_d  = w1_q;
    w2_d  = w2_q;
    rej_d = rej_q;
    if (MANCHE == 2'b01) begin
      if (w1_q != 5'd31) w1_d = w1_q + 5'd1;
    end else if (MANCHE == 2'b10) begin
      if (w2_q != 5'd31) w2_d = w2_q + 5'd1;
    end else if (MANCHE == 2'b00) begin
      if (((mv1_q | mv2_q) != 2'b00) && (rej_q != 5'd31)) rej_d = rej_q + 5'd1;
    end
    total_d = {2'b00, w1_d} + {2'b00, w2_d} + {2'b00, rej_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      primo_q   <= 2'b00;
      secondo_q <= 2'b00;
      inizia_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 2'b00;
      mv1_q     <= 2'b00;
      mv2_q     <= 2'b00;
      w1_q      <= 5'd0;
      w2_q      <= 5'd0;
      rej_q     <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_INIT;
            inizia_q  <= 1'b1;
            primo_q   <= n_extra[3:2];
            secondo_q <= n_extra[1:0];
            busy_q    <= 1'b1;
            result_q  <= 2'b00;
            w1_q      <= 5'd0;
            w2_q      <= 5'd0;
            rej_q     <= 5'd0;
          end
        end
        S_INIT: begin
          state_q   <= S_WAIT;
          inizia_q  <= 1'b0;
          primo_q   <= 2'b00;
          secondo_q <= 2'b00;
          ready_q   <= 1'b1;
        end
        S_WAIT: begin
          if (move_valid && ready_q) begin
            state_q   <= S_ISSUE;
            mv1_q     <= move_p1;
            mv2_q     <= move_p2;
            primo_q   <= move_p1;
            secondo_q <= move_p2;
            ready_q   <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_q   <= S_COLLECT;
          primo_q   <= 2'b00;
          secondo_q <= 2'b00;
        end
        S_COLLECT: begin
          w1_q  <= w1_d;
          w2_q  <= w2_d;
          rej_q <= rej_d;
          if (PARTITA != 2'b00) begin
            result_q <= PARTITA;
            done_q   <= 1'b1;
            state_q  <= S_FINISH;
          end else if (total_d >= 7'd31) begin
            // Referee never decided: give up with the aborted code.
            result_q <= 2'b00;
            done_q   <= 1'b1;
            state_q  <= S_FINISH;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign move_ready = ready_q;
  assign PRIMO      = primo_q;
  assign SECONDO    = secondo_q;
  assign INIZIA     = inizia_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign wins_p1    = w1_q;
  assign wins_p2    = w2_q;
  assign rejected   = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_morra_driver.sv
`default_nettype none
// tb_morra_driver: directed scenarios for morra_driver against a small behavioural referee.
module tb_morra_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] n_extra = 4'd0;
  logic       move_valid = 1'b0;
  logic [1:0] move_p1 = 2'b00, move_p2 = 2'b00;
  logic       move_ready, INIZIA, busy, done;
  logic [1:0] PRIMO, SECONDO, MANCHE, PARTITA, result;
  logic [4:0] wins_p1, wins_p2, rejected;

  int total = 0;
  int bad   = 0;
  int iz_cnt = 0;
  int done_cnt = 0;
  logic ref_mode = 1'b0;  // 0: rule-following referee, 1: stub that never ends a match

  always #5 clk = ~clk;

  morra_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_extra(n_extra),
    .move_valid(move_valid), .move_p1(move_p1), .move_p2(move_p2),
    .move_ready(move_ready), .PRIMO(PRIMO), .SECONDO(SECONDO), .INIZIA(INIZIA),
    .MANCHE(MANCHE), .PARTITA(PARTITA), .busy(busy), .done(done), .result(result),
    .wins_p1(wins_p1), .wins_p2(wins_p2), .rejected(rejected)
  );

  always_ff @(posedge clk) begin
    if (INIZIA) iz_cnt <= iz_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  // Referee: answers one cycle after a nonzero pair; a winner may not repeat its winning move.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10);
  endfunction

  logic [1:0] r_man_q, r_par_q, r_lastw_q, r_lastmv_q;
  logic [4:0] r_rounds_q, r_c1_q, r_c2_q, r_limit_q;
  logic [1:0] n_man, n_par, n_lastw, n_lastmv;
  logic [4:0] n_rounds, n_c1, n_c2, n_limit;

  always_comb begin
    n_man = 2'b00; n_par = 2'b00;
    n_lastw = r_lastw_q; n_lastmv = r_lastmv_q;
    n_rounds = r_rounds_q; n_c1 = r_c1_q; n_c2 = r_c2_q; n_limit = r_limit_q;
    if (INIZIA) begin
      n_lastw = 2'd0; n_lastmv = 2'd0; n_rounds = 5'd0; n_c1 = 5'd0; n_c2 = 5'd0;
      n_limit = {1'b0, PRIMO, SECONDO} + 5'd4;
    end else if (PRIMO != 2'b00 || SECONDO != 2'b00) begin
      if (ref_mode) n_man = 2'b01;
      else if (PRIMO == 2'b00 || SECONDO == 2'b00 ||
               (r_lastw_q == 2'd1 && PRIMO == r_lastmv_q) ||
               (r_lastw_q == 2'd2 && SECONDO == r_lastmv_q)) n_man = 2'b00;
      else begin
        if (beats(PRIMO, SECONDO)) begin
          n_man = 2'b01; n_c1 = r_c1_q + 5'd1; n_lastw = 2'd1; n_lastmv = PRIMO;
        end else if (beats(SECONDO, PRIMO)) begin
          n_man = 2'b10; n_c2 = r_c2_q + 5'd1; n_lastw = 2'd2; n_lastmv = SECONDO;
        end else begin
          n_man = 2'b11; n_lastw = 2'd0;
        end
        n_rounds = r_rounds_q + 5'd1;
        if (n_rounds >= r_limit_q)
          n_par = (n_c1 > n_c2) ? 2'b01 : ((n_c2 > n_c1) ? 2'b10 : 2'b11);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_man_q <= 2'b00; r_par_q <= 2'b00; r_lastw_q <= 2'd0; r_lastmv_q <= 2'd0;
      r_rounds_q <= 5'd0; r_c1_q <= 5'd0; r_c2_q <= 5'd0; r_limit_q <= 5'd4;
    end else begin
      r_man_q <= n_man; r_par_q <= n_par; r_lastw_q <= n_lastw; r_lastmv_q <= n_lastmv;
      r_rounds_q <= n_rounds; r_c1_q <= n_c1; r_c2_q <= n_c2; r_limit_q <= n_limit;
    end
  end
  assign MANCHE  = r_man_q;
  assign PARTITA = r_par_q;

  // Pulses start; returns at the falling edge inside INIT.
  task automatic start_match(input logic [3:0] ne);
    @(negedge clk); n_extra = ne; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // One full handshake; returns at the falling edge after the round was collected.
  task automatic play(input logic [1:0] p1, input logic [1:0] p2);
    int k;
    k = 0;
    while (!move_ready && k < 20) begin @(negedge clk); k++; end
    total++;
    if (!move_ready) begin bad++; $display("FAIL ready_timeout: move_ready=%b want 1", move_ready); end
    move_valid = 1'b1; move_p1 = p1; move_p2 = p2;
    @(posedge clk); @(negedge clk); move_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (busy !== 1'b0 || done !== 1'b0 || move_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ctrl: busy=%b done=%b ready=%b want 0 0 0", busy, done, move_ready); end
    total++; if (PRIMO !== 2'b00 || SECONDO !== 2'b00 || INIZIA !== 1'b0 || result !== 2'b00) begin bad++;
      $display("FAIL reset_ref: P=%b S=%b I=%b res=%b want 00 00 0 00", PRIMO, SECONDO, INIZIA, result); end
    total++; if (wins_p1 !== 5'd0 || wins_p2 !== 5'd0 || rejected !== 5'd0) begin bad++;
      $display("FAIL reset_tally: %0d %0d %0d want 0 0 0", wins_p1, wins_p2, rejected); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || move_ready !== 1'b0) begin bad++;
      $display("FAIL reset_idle: busy=%b ready=%b want 0 0", busy, move_ready); end
  endtask

  task automatic test_p1_wins;
    start_match(4'd0);
    total++; if (INIZIA !== 1'b1 || PRIMO !== 2'b00 || SECONDO !== 2'b00 || busy !== 1'b1) begin bad++;
      $display("FAIL init0: I=%b P=%b S=%b busy=%b want 1 00 00 1", INIZIA, PRIMO, SECONDO, busy); end
    play(2'b01, 2'b11);
    total++; if (wins_p1 !== 5'd1 || rejected !== 5'd0) begin bad++;
      $display("FAIL first_win: w1=%0d rej=%0d want 1 0", wins_p1, rejected); end
    play(2'b01, 2'b11);
    total++; if (wins_p1 !== 5'd1 || rejected !== 5'd1) begin bad++;
      $display("FAIL repeat_reject: w1=%0d rej=%0d want 1 1", wins_p1, rejected); end
    play(2'b10, 2'b01);
    play(2'b11, 2'b10);
    total++; if (done !== 1'b0 || wins_p1 !== 5'd3) begin bad++;
      $display("FAIL third_win: done=%b w1=%0d want 0 3", done, wins_p1); end
    play(2'b01, 2'b11);
    total++; if (done !== 1'b1 || result !== 2'b01 || wins_p1 !== 5'd4 || wins_p2 !== 5'd0) begin bad++;
      $display("FAIL p1_match: done=%b res=%b w1=%0d w2=%0d want 1 01 4 0", done, result, wins_p1, wins_p2); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || result !== 2'b01) begin bad++;
      $display("FAIL p1_hold: busy=%b done=%b res=%b want 0 0 01", busy, done, result); end
  endtask

  task automatic test_ties;
    start_match(4'd1);
    total++; if (INIZIA !== 1'b1 || PRIMO !== 2'b00 || SECONDO !== 2'b01 || wins_p1 !== 5'd0 || result !== 2'b00) begin bad++;
      $display("FAIL init1: I=%b P=%b S=%b w1=%0d res=%b want 1 00 01 0 00", INIZIA, PRIMO, SECONDO, wins_p1, result); end
    for (int i = 0; i < 4; i++) play(2'b10, 2'b10);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL tie_4th: done=%b busy=%b want 0 1", done, busy); end
    play(2'b10, 2'b10);
    total++; if (done !== 1'b1 || result !== 2'b11 || wins_p1 !== 5'd0 || wins_p2 !== 5'd0 || rejected !== 5'd0) begin bad++;
      $display("FAIL tie_match: done=%b res=%b tallies=%0d/%0d/%0d want 1 11 0/0/0", done, result, wins_p1, wins_p2, rejected); end
    @(negedge clk);
  endtask

  task automatic test_handshake;
    start_match(4'd0);
    @(negedge clk);
    move_valid = 1'b1; move_p1 = 2'b01; move_p2 = 2'b11;
    for (int k = 0; k < 9; k++) begin
      total++; if (move_ready !== ((k % 3) == 0)) begin bad++;
        $display("FAIL hs_ready_%0d: ready=%b want %b", k, move_ready, ((k % 3) == 0)); end
      @(negedge clk);
    end
    move_valid = 1'b0;
    total++; if (wins_p1 !== 5'd1 || rejected !== 5'd2 || wins_p2 !== 5'd0 || move_ready !== 1'b1) begin bad++;
      $display("FAIL hs_consumed: w1=%0d rej=%0d w2=%0d ready=%b want 1 2 0 1", wins_p1, rejected, wins_p2, move_ready); end
  endtask

  task automatic test_start_while_busy;
    int iz0;
    iz0 = iz_cnt;
    start = 1'b1;
    play(2'b10, 2'b01);
    start = 1'b0;
    total++; if (iz_cnt !== iz0 || busy !== 1'b1) begin bad++;
      $display("FAIL busy_start_init: inits=%0d busy=%b want %0d 1", iz_cnt, busy, iz0); end
    total++; if (wins_p1 !== 5'd2 || rejected !== 5'd2) begin bad++;
      $display("FAIL busy_start_tally: w1=%0d rej=%0d want 2 2", wins_p1, rejected); end
  endtask

  task automatic test_reset_mid_match;
    int d0;
    d0 = done_cnt;
    move_valid = 1'b1; move_p1 = 2'b11; move_p2 = 2'b10;
    @(posedge clk); @(negedge clk); move_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || move_ready !== 1'b0 || PRIMO !== 2'b00 || INIZIA !== 1'b0) begin bad++;
      $display("FAIL rstmid_ctrl: busy=%b ready=%b P=%b I=%b want 0 0 00 0", busy, move_ready, PRIMO, INIZIA); end
    total++; if (wins_p1 !== 5'd0 || rejected !== 5'd0 || result !== 2'b00) begin bad++;
      $display("FAIL rstmid_tally: w1=%0d rej=%0d res=%b want 0 0 00", wins_p1, rejected, result); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done_cnt !== d0) begin bad++;
      $display("FAIL rstmid_nodone: busy=%b dones=%0d want 0 %0d", busy, done_cnt, d0); end
    start_match(4'd0);
    play(2'b01, 2'b11); play(2'b10, 2'b01); play(2'b11, 2'b10); play(2'b01, 2'b11);
    total++; if (done !== 1'b1 || result !== 2'b01 || wins_p1 !== 5'd4 || rejected !== 5'd0) begin bad++;
      $display("FAIL rstmid_clean: done=%b res=%b w1=%0d rej=%0d want 1 01 4 0", done, result, wins_p1, rejected); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    ref_mode = 1'b1;
    start_match(4'd14);
    total++; if (INIZIA !== 1'b1 || PRIMO !== 2'b11 || SECONDO !== 2'b10) begin bad++;
      $display("FAIL init14: I=%b P=%b S=%b want 1 11 10", INIZIA, PRIMO, SECONDO); end
    for (int i = 0; i < 30; i++) play(2'b01, 2'b11);
    total++; if (done !== 1'b0 || busy !== 1'b1 || wins_p1 !== 5'd30) begin bad++;
      $display("FAIL abort_30: done=%b busy=%b w1=%0d want 0 1 30", done, busy, wins_p1); end
    play(2'b01, 2'b11);
    total++; if (done !== 1'b1 || result !== 2'b00 || wins_p1 !== 5'd31 || wins_p2 !== 5'd0 || rejected !== 5'd0) begin bad++;
      $display("FAIL abort_31: done=%b res=%b tallies=%0d/%0d/%0d want 1 00 31/0/0", done, result, wins_p1, wins_p2, rejected); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || wins_p1 !== 5'd31 || result !== 2'b00) begin bad++;
      $display("FAIL abort_idle: busy=%b done=%b w1=%0d res=%b want 0 0 31 00", busy, done, wins_p1, result); end
    ref_mode = 1'b0;
  endtask

  initial begin
    test_reset;
    test_p1_wins;
    test_ties;
    test_handshake;
    test_start_while_busy;
    test_reset_mid_match;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
